// File: rtl/atan_ratio_div.sv
// First-octant reduction of a signed (x, y) vector followed by a restoring divider
// that produces the unsigned Q0.Q_W ratio min/max for the polynomial atan stage.
module atan_ratio_div #(
    parameter int IN_W = 16,
    parameter int Q_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            val_i,
    output logic            rdy_o,
    input  logic [IN_W-1:0] x_i,
    input  logic [IN_W-1:0] y_i,
    output logic            val_o,
    output logic [Q_W-1:0]  ratio_o,
    output logic [2:0]      oct_o,
    output logic            zero_o
);
    localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

    state_t           r_state, w_next;
    logic [IN_W-1:0]  r_x, r_y, r_max;
    logic [IN_W:0]    r_rem;
    logic [Q_W-1:0]   r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_xneg, r_yneg, r_swap, r_zero;
    logic             r_val, r_zero_o;
    logic [Q_W-1:0]   r_ratio;
    logic [2:0]       r_oct;

    logic [IN_W-1:0]  w_ax, w_ay, w_max, w_min;
    logic             w_swap, w_ge;
    logic [IN_W:0]    w_rem2, w_rem_nx;
    logic [Q_W-1:0]   w_q_nx;

    // Unsigned negate keeps the most negative input representable as 2^(IN_W-1).
    assign w_ax   = r_x[IN_W-1] ? (~r_x + IN_W'(1)) : r_x;
    assign w_ay   = r_y[IN_W-1] ? (~r_y + IN_W'(1)) : r_y;
    assign w_swap = (w_ay > w_ax);
    assign w_max  = w_swap ? w_ay : w_ax;
    assign w_min  = w_swap ? w_ax : w_ay;

    // rem never exceeds max, so the doubled value always fits in IN_W+1 bits.
    assign w_rem2   = {r_rem[IN_W-1:0], 1'b0};
    assign w_ge     = (w_rem2 >= {1'b0, r_max});
    assign w_rem_nx = w_ge ? (w_rem2 - {1'b0, r_max}) : w_rem2;
    assign w_q_nx   = r_q | (Q_W'(w_ge) << r_cnt);

    always_comb begin
        w_next = r_state;
        rdy_o  = 1'b0;
        case (r_state)
            IDLE: begin
                rdy_o = ~rst;
                if (val_i) w_next = PREP;
            end
            PREP:    w_next = DIV;
            DIV:     if (r_cnt == '0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_max    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_xneg   <= 1'b0;
            r_yneg   <= 1'b0;
            r_swap   <= 1'b0;
            r_zero   <= 1'b0;
            r_val    <= 1'b0;
            r_ratio  <= '0;
            r_oct    <= '0;
            r_zero_o <= 1'b0;
        end else begin
            r_val <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (val_i) begin
                        r_x <= x_i;
                        r_y <= y_i;
                    end
                end
                PREP: begin
                    r_xneg <= r_x[IN_W-1];
                    r_yneg <= r_y[IN_W-1];
                    r_swap <= w_swap;
                    r_max  <= w_max;
                    r_zero <= (w_max == '0);
                    r_rem  <= {1'b0, w_min};
                    r_q    <= '0;
                    r_cnt  <= CNT_W'(Q_W - 1);
                end
                DIV: begin
                    r_rem <= w_rem_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt - 1'b1;
                    // Results are latched on the last quotient bit so they are valid during DONE.
                    if (r_cnt == '0) begin
                        r_val    <= 1'b1;
                        r_ratio  <= r_zero ? '0 : w_q_nx;
                        r_oct    <= {r_xneg, r_yneg, r_swap};
                        r_zero_o <= r_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign val_o   = r_val;
    assign ratio_o = r_ratio;
    assign oct_o   = r_oct;
    assign zero_o  = r_zero_o;
endmodule

// File: doc/atan_ratio_div.md
Name: atan_ratio_div

Overview:
Front-end stage of the atan2 datapath. It sits directly upstream of the 8-bit-input polynomial atan stage. It accepts a signed (x, y) vector and reduces it to the first octant: abs values, then a swap so that min <= max. An iterative restoring divider then produces the 8-bit ratio min/max in unsigned Q0.8, which drives the polynomial's ratio input. Octant flags are produced alongside the ratio so a later stage can reconstruct the full-circle angle.

Parameters:
IN_W, 16, width of signed x_i/y_i (two's complement)
Q_W, 8, ratio width; must equal the polynomial stage input width; iteration count = Q_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
val_i  input  1  input vector valid
rdy_o  output  1  block ready to accept a vector
x_i  input  IN_W  signed x component
y_i  input  IN_W  signed y component
val_o  output  1  single-cycle pulse, ratio_o/oct_o/zero_o valid
ratio_o  output  Q_W  unsigned Q0.8 ratio min/max, drives polynomial input
oct_o  output  3  {x_neg, y_neg, swap}
zero_o  output  1  input was x=0 and y=0

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high. rst overrides all other inputs.
- Reset values: state=IDLE, val_o=0, ratio_o=0, oct_o=0, zero_o=0, all internal registers 0. rdy_o=0 while rst=1.
- FSM states:
  - IDLE: rdy_o=1. Accept when val_i=1, which registers x_i/y_i; go to PREP. val_i while not in IDLE is ignored and never queued.
  - PREP, 1 cycle:
    - x_neg=x_i[MSB], y_neg=y_i[MSB].
    - ax=|x|, ay=|y| as IN_W-bit unsigned; -2^(IN_W-1) maps to 2^(IN_W-1) with no overflow.
    - swap=(ay>ax); max=swap?ay:ax, min=swap?ax:ay.
    - zero flag = (max==0).
    - rem=min in an (IN_W+1)-bit register; iteration counter=Q_W-1.
    - Go to DIV.
  - DIV, Q_W cycles, one quotient bit per cycle, MSB first:
    - rem2 = rem<<1.
    - If rem2>=max: rem=rem2-max, q[cnt]=1. Else rem=rem2, q[cnt]=0.
    - Counter decrements. After the cycle with cnt=0, go to DONE.
  - DONE, 1 cycle:
    - val_o=1, ratio_o = zero ? 0 : q, oct_o and zero_o driven.
    - Next state is IDLE.
- Arithmetic result: ratio_o = min(2^Q_W-1, floor(2^Q_W*min/max)).
  - min==max yields all-ones (0xFF) naturally from the algorithm.
  - max==0 is forced to 0 with zero_o=1; the divider output is discarded.
- Latency: accept at cycle T (val_i & rdy_o), val_o at T+Q_W+2 (T+10 at default). rdy_o returns at T+Q_W+3.
  - Maximum throughput: one vector per Q_W+3 cycles (11 at default).
- Output holding: val_o is exactly 1 cycle. ratio_o, oct_o and zero_o hold their last result until the next DONE; they are not cleared by IDLE.
  - The polynomial stage samples ratio on val_o. oct_o must be delayed externally to match that stage's latency.
- rst asserted in any state: the next cycle is IDLE with all outputs at reset values. The in-flight vector is dropped and no val_o is produced for it.
- val_i and rst in the same cycle: rst wins and nothing is accepted.

Test Plan:
- Basic, no swap: rst 2 cycles, then x=100, y=50, val_i 1 cycle -> val_o pulse exactly 10 cycles after accept, ratio_o=0x80, oct_o=3'b000, zero_o=0. rdy_o=0 from the cycle after accept until val_o, and high the cycle after val_o.
- Swap with negative x: x=-100, y=200 -> ratio_o=0x80, oct_o=3'b101. Then x=30, y=-90 -> ratio_o=floor(256*30/90)=0x55, oct_o=3'b011.
- Boundaries:
  - x=1000, y=-1000 -> ratio_o=0xFF, oct_o=3'b010 (no swap on equality).
  - x=0, y=0 -> ratio_o=0x00, zero_o=1, oct_o=3'b000.
  - x=-32768, y=1 -> max=32768, ratio_o=0x00, oct_o=3'b100, zero_o=0.
- Back-to-back: val_i held high with a new vector each cycle for 40 cycles -> exactly one accept per 11 cycles (accepts at rdy_o cycles only), 4 val_o pulses. Each ratio matches the vector present on its accept cycle.
- Reset mid-operation: accept x=100, y=50, assert rst for 1 cycle during DIV (4 cycles after accept) -> no val_o for that vector. ratio_o/oct_o read 0 after reset; rdy_o=1 the cycle after rst drops. A new vector then completes normally with 10-cycle latency.
- Random compare: 10k random signed (x, y) pairs -> every val_o matches a reference model of floor(256*min/max) with saturation and the zero rule, and the matching oct_o.
